// File: rtl/conv_loop_gen.sv
// Loop-nest sequencer for the conv datapath: walks oc>oy>ox>ky>kx>ic and emits
// one beat per step with input/weight/output addresses and accumulate markers.
module conv_loop_gen #(
  parameter int CW      = 8,
  parameter int AW      = 16,
  parameter int IM_H    = 32,
  parameter int IM_W    = 32,
  parameter int IN_CH   = 3,
  parameter int OUT_CH  = 32,
  parameter int K_H     = 5,
  parameter int K_W     = 5,
  parameter int OUT_H   = 32,
  parameter int OUT_W   = 32,
  parameter int STRIDE  = 1,
  parameter int PADDING = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  input  logic                 ready,
  output logic [CW-1:0]        oc,
  output logic [CW-1:0]        oy,
  output logic [CW-1:0]        ox,
  output logic [CW-1:0]        ky,
  output logic [CW-1:0]        kx,
  output logic [CW-1:0]        ic,
  output logic signed [CW-1:0] in_row,
  output logic signed [CW-1:0] in_col,
  output logic                 pad,
  output logic [AW-1:0]        in_addr,
  output logic [AW-1:0]        w_addr,
  output logic [AW-1:0]        out_addr,
  output logic                 acc_first,
  output logic                 acc_last
);

  localparam int NL = 6;
  localparam int XW = CW + 2;
  // Index 0 is the fastest-moving loop.
  localparam int LIM [NL] = '{IN_CH, K_W, K_H, OUT_W, OUT_H, OUT_CH};

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state_q, state_d;
  logic [NL-1:0][CW-1:0] cnt_q;
  logic [NL-1:0]        at_max;
  logic [NL-1:0]        carry;
  logic                 clr, step;

  assign carry[0] = step;

  genvar g;
  for (g = 0; g < NL; g++) begin : g_loop
    assign at_max[g] = (cnt_q[g] == CW'(LIM[g] - 1));
    if (g < NL - 1) begin : g_carry
      assign carry[g+1] = carry[g] & at_max[g];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NL; i++) begin
        if (clr)           cnt_q[i] <= '0;
        else if (carry[i]) cnt_q[i] <= at_max[i] ? '0 : cnt_q[i] + CW'(1);
      end
    end
  end

  // Final acceptance lets every counter wrap, so they sit at 0 in FIN/IDLE.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        clr     = 1'b1;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else if (ready) begin
          step = 1'b1;
          if (&at_max) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        clr     = abort;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign valid = (state_q == RUN);
  assign done  = (state_q == FIN) && !abort;

  assign ic = cnt_q[0];
  assign kx = cnt_q[1];
  assign ky = cnt_q[2];
  assign ox = cnt_q[3];
  assign oy = cnt_q[4];
  assign oc = cnt_q[5];

  logic signed [XW-1:0] row_x, col_x;
  int                   row_i, col_i;

  assign row_x  = XW'(STRIDE * int'(oy) + int'(ky) - PADDING);
  assign col_x  = XW'(STRIDE * int'(ox) + int'(kx) - PADDING);
  assign row_i  = int'(row_x);
  assign col_i  = int'(col_x);
  assign in_row = row_x[CW-1:0];
  assign in_col = col_x[CW-1:0];
  assign pad    = (row_i < 0) || (row_i >= IM_H) || (col_i < 0) || (col_i >= IM_W);

  longint ia_l, wa_l, oa_l;

  assign ia_l = (longint'(row_i) * IM_W + longint'(col_i)) * IN_CH + longint'(ic);
  assign wa_l = ((longint'(oc) * K_H + longint'(ky)) * K_W + longint'(kx)) * IN_CH + longint'(ic);
  assign oa_l = (longint'(oc) * OUT_H + longint'(oy)) * OUT_W + longint'(ox);

  assign in_addr  = pad ? '0 : AW'(ia_l);
  assign w_addr   = AW'(wa_l);
  assign out_addr = AW'(oa_l);

  assign acc_first = (ky == '0) && (kx == '0) && (ic == '0);
  assign acc_last  = (ky == CW'(K_H - 1)) && (kx == CW'(K_W - 1)) && (ic == CW'(IN_CH - 1));

endmodule

// File: tb/tb_conv_loop_gen.sv
// Bench for conv_loop_gen: two configurations, beats checked against an
// index-decomposition model, with stalls, abort and reset mid-pass.
module tb_conv_loop_gen;
  localparam int CW = 8;
  localparam int AW = 16;
  localparam int TOT_A = 2*4*4*3*3*2;
  localparam int TOT_B = 1*2*2*2*2*1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic a_start, a_abort, a_ready, a_busy, a_done, a_valid, a_pad, a_af, a_al;
  logic [CW-1:0] a_oc, a_oy, a_ox, a_ky, a_kx, a_ic;
  logic signed [CW-1:0] a_row, a_col;
  logic [AW-1:0] a_in, a_w, a_out;

  logic b_start, b_abort, b_ready, b_busy, b_done, b_valid, b_pad, b_af, b_al;
  logic [CW-1:0] b_oc, b_oy, b_ox, b_ky, b_kx, b_ic;
  logic signed [CW-1:0] b_row, b_col;
  logic [AW-1:0] b_in, b_w, b_out;

  conv_loop_gen #(.CW(CW), .AW(AW), .IM_H(4), .IM_W(4), .IN_CH(2), .OUT_CH(2),
    .K_H(3), .K_W(3), .OUT_H(4), .OUT_W(4), .STRIDE(1), .PADDING(1)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .abort(a_abort), .busy(a_busy),
    .done(a_done), .valid(a_valid), .ready(a_ready), .oc(a_oc), .oy(a_oy),
    .ox(a_ox), .ky(a_ky), .kx(a_kx), .ic(a_ic), .in_row(a_row), .in_col(a_col),
    .pad(a_pad), .in_addr(a_in), .w_addr(a_w), .out_addr(a_out),
    .acc_first(a_af), .acc_last(a_al));

  conv_loop_gen #(.CW(CW), .AW(AW), .IM_H(4), .IM_W(4), .IN_CH(1), .OUT_CH(1),
    .K_H(2), .K_W(2), .OUT_H(2), .OUT_W(2), .STRIDE(2), .PADDING(0)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .busy(b_busy),
    .done(b_done), .valid(b_valid), .ready(b_ready), .oc(b_oc), .oy(b_oy),
    .ox(b_ox), .ky(b_ky), .kx(b_kx), .ic(b_ic), .in_row(b_row), .in_col(b_col),
    .pad(b_pad), .in_addr(b_in), .w_addr(b_w), .out_addr(b_out),
    .acc_first(b_af), .acc_last(b_al));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int oc, oy, ox, ky, kx, ic, row, col, pad, ia, wa, oa, af, al;
  } beat_t;

  // Beat n of a pass, obtained by splitting n into mixed-radix loop digits.
  function automatic beat_t model(input int n, input int imh, input int imw,
      input int ich, input int kh, input int kw, input int oh, input int ow,
      input int s, input int p);
    beat_t b;
    int r;
    r = n;
    b.ic = r % ich; r = r / ich;
    b.kx = r % kw;  r = r / kw;
    b.ky = r % kh;  r = r / kh;
    b.ox = r % ow;  r = r / ow;
    b.oy = r % oh;  r = r / oh;
    b.oc = r;
    b.row = s*b.oy + b.ky - p;
    b.col = s*b.ox + b.kx - p;
    b.pad = (b.row < 0 || b.row >= imh || b.col < 0 || b.col >= imw) ? 1 : 0;
    b.ia  = b.pad ? 0 : ((b.row*imw + b.col)*ich + b.ic) % 65536;
    b.wa  = (((b.oc*kh + b.ky)*kw + b.kx)*ich + b.ic) % 65536;
    b.oa  = ((b.oc*oh + b.oy)*ow + b.ox) % 65536;
    b.af  = (b.ky == 0 && b.kx == 0 && b.ic == 0) ? 1 : 0;
    b.al  = (b.ky == kh-1 && b.kx == kw-1 && b.ic == ich-1) ? 1 : 0;
    return b;
  endfunction

  task automatic check_a(input int n);
    beat_t e;
    e = model(n, 4, 4, 2, 3, 3, 4, 4, 1, 1);
    chk("a_oc", int'(a_oc), e.oc);   chk("a_oy", int'(a_oy), e.oy);
    chk("a_ox", int'(a_ox), e.ox);   chk("a_ky", int'(a_ky), e.ky);
    chk("a_kx", int'(a_kx), e.kx);   chk("a_ic", int'(a_ic), e.ic);
    chk("a_row", int'(a_row), e.row); chk("a_col", int'(a_col), e.col);
    chk("a_pad", int'(a_pad), e.pad); chk("a_in_addr", int'(a_in), e.ia);
    chk("a_w_addr", int'(a_w), e.wa); chk("a_out_addr", int'(a_out), e.oa);
    chk("a_acc_first", int'(a_af), e.af); chk("a_acc_last", int'(a_al), e.al);
    if (n == 0) begin
      chk("a_b0_row", int'(a_row), -1); chk("a_b0_col", int'(a_col), -1);
      chk("a_b0_pad", int'(a_pad), 1);  chk("a_b0_in", int'(a_in), 0);
      chk("a_b0_w", int'(a_w), 0);      chk("a_b0_first", int'(a_af), 1);
    end
    if (n == 9) begin
      chk("a_b9_row", int'(a_row), 0);  chk("a_b9_col", int'(a_col), 0);
      chk("a_b9_pad", int'(a_pad), 0);  chk("a_b9_in", int'(a_in), 1);
      chk("a_b9_w", int'(a_w), 9);      chk("a_b9_out", int'(a_out), 0);
      chk("a_b9_first", int'(a_af), 0); chk("a_b9_last", int'(a_al), 0);
    end
    if (n == TOT_A-1) begin
      chk("a_end_oc", int'(a_oc), 1);   chk("a_end_oy", int'(a_oy), 3);
      chk("a_end_ox", int'(a_ox), 3);   chk("a_end_out", int'(a_out), 31);
      chk("a_end_last", int'(a_al), 1);
    end
  endtask

  task automatic quiet_a(input string tag);
    chk({tag, "_valid"}, int'(a_valid), 0);
    chk({tag, "_busy"}, int'(a_busy), 0);
    chk({tag, "_done"}, int'(a_done), 0);
    chk({tag, "_cnt"}, int'(a_oc)+int'(a_oy)+int'(a_ox)+int'(a_ky)+int'(a_kx)+int'(a_ic), 0);
  endtask

  // One pass on instance A. kill_at >= 0 ends it early by abort or reset.
  task automatic run_a(input bit bp, input int start_at, input int kill_at, input bit kill_rst);
    int beats, cyc;
    beats = 0;
    cyc = 0;
    @(negedge clk);
    a_start = 1'b1; a_ready = 1'b1;
    chk("a_pre_valid", int'(a_valid), 0);
    @(negedge clk);
    a_start = 1'b0;
    chk("a_valid_rise", int'(a_valid), 1);
    chk("a_busy_rise", int'(a_busy), 1);
    while (beats < TOT_A && cyc < 5000) begin
      a_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      a_start = (beats == start_at);
      chk("a_valid", int'(a_valid), 1);
      chk("a_no_early_done", int'(a_done), 0);
      check_a(beats);
      if (beats == kill_at) begin
        if (kill_rst) reset = 1'b1; else a_abort = 1'b1;
        @(negedge clk);
        reset = 1'b0; a_abort = 1'b0; a_start = 1'b0;
        quiet_a(kill_rst ? "a_rst" : "a_abort");
        if (kill_rst) begin
          chk("a_rst_w", int'(a_w), 0);
          chk("a_rst_out", int'(a_out), 0);
        end
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("a_kill_no_done", int'(a_done), 0);
        end
        return;
      end
      if (a_ready) beats++;
      @(negedge clk);
      cyc++;
    end
    a_start = 1'b0;
    chk("a_timeout", (cyc < 5000) ? 1 : 0, 1);
    chk("a_beats", beats, TOT_A);
    chk("a_done_pulse", int'(a_done), 1);
    chk("a_fin_valid", int'(a_valid), 0);
    chk("a_fin_busy", int'(a_busy), 0);
    @(negedge clk);
    chk("a_done_once", int'(a_done), 0);
    chk("a_idle_cnt", int'(a_oc)+int'(a_ic), 0);
  endtask

  task automatic run_b();
    beat_t e;
    int beats;
    beats = 0;
    @(negedge clk);
    b_start = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (beats < TOT_B && b_valid) begin
      e = model(beats, 4, 4, 1, 2, 2, 2, 2, 2, 0);
      chk("b_row", int'(b_row), e.row);    chk("b_col", int'(b_col), e.col);
      chk("b_in_addr", int'(b_in), e.ia);  chk("b_w_addr", int'(b_w), e.wa);
      chk("b_out_addr", int'(b_out), e.oa);
      chk("b_both_mark", int'(b_af)+int'(b_al), e.af+e.al);
      chk("b_nopad", int'(b_pad), 0);
      if (beats == 13) begin
        chk("b_b13_row", int'(b_row), 2); chk("b_b13_col", int'(b_col), 3);
        chk("b_b13_in", int'(b_in), 11);
      end
      beats++;
      @(negedge clk);
    end
    chk("b_beats", beats, TOT_B);
    chk("b_done", int'(b_done), 1);
  endtask

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    quiet_a("a_reset");
    chk("b_reset_valid", int'(b_valid), 0);
    chk("b_reset_done", int'(b_done), 0);

    run_a(1'b0, 100, -1, 1'b0);
    run_a(1'b0, -1, 50, 1'b0);
    run_a(1'b0, -1, 30, 1'b1);
    run_a(1'b1, 200, -1, 1'b0);
    run_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
